// File: rtl/inv_subbytes_iter.sv
// AES-128 inverse SubBytes: LANES inverse S-box lookups time-shared over 16/LANES beats.
// Accepts a state when idle, substitutes one byte group per cycle, then pulses valid_out.
module inv_subbytes_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  input  logic [127:0] data_in,
  output logic         in_ready,
  output logic         valid_out,
  output logic [127:0] data_out,
  output logic         overrun
);

  localparam int unsigned BEATS = 16 / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned GW    = 8 * LANES;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 inverse S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry b sits at bit offset 8*(255-b), and 255-b is simply ~b.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  work_q, work_d;
  logic [127:0]  dout_q, dout_d;
  logic          vout_q, vout_d;
  logic          ovr_q, ovr_d;
  logic [6:0]    bit_base;
  logic [GW-1:0] grp, grp_sub;

  // Only LANES lookups exist; the active byte group is muxed through them.
  assign bit_base = 7'(cnt_q) * 7'(GW);
  assign grp      = work_q[bit_base +: GW];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign grp_sub[8*l +: 8] = inv_sbox(grp[8*l +: 8]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    dout_d  = dout_q;
    vout_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          work_d  = data_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Inputs offered while busy are dropped and flagged.
        ovr_d = valid_in;
        work_d[bit_base +: GW] = grp_sub;
        if (cnt_q == LAST_BEAT) begin
          dout_d  = work_d;
          vout_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign valid_out = vout_q;
  assign data_out  = dout_q;
  assign overrun   = ovr_q;

endmodule
